vpipe_inst_issuer: RTL and testbench

- Instruction source for the vpipe refinement benches: the driving end of the instruction input that the pipeline and ILA model consume.
- Buffers host-pushed 8-bit instructions in a small FIFO and issues at most one per cycle on a registered `inst` bus.
- Inserts NOP bubbles on RAW hazards when interlocking is enabled.
- Tracks in-flight instructions to a retire point, so checkers get issue/retire timing and a saturating cycle count.

---
 rtl/vpipe_inst_issuer_if.sv | 28 ++
 rtl/vpipe_inst_issuer.sv | 104 ++++++++++
 tb/tb_vpipe_inst_issuer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpipe_inst_issuer_if.sv
// Host-side push/stall handshake and the issue/retire observation bus of the
// vpipe instruction issuer.
interface vpipe_inst_issuer_if;
  logic       push_valid;
  logic [7:0] push_inst;
  logic       push_ready;
  logic       stall;
  logic [7:0] inst;
  logic       issue;
  logic       retire_valid;
  logic [1:0] retire_rd;
  logic [1:0] retire_op;
  logic [2:0] inflight;
  logic       busy;
  logic [3:0] cycle_cnt;

  modport master (
    output push_valid, push_inst, stall,
    input  push_ready, inst, issue, retire_valid, retire_rd, retire_op,
           inflight, busy, cycle_cnt
  );

  modport slave (
    input  push_valid, push_inst, stall,
    output push_ready, inst, issue, retire_valid, retire_rd, retire_op,
           inflight, busy, cycle_cnt
  );
endinterface

// File: rtl/vpipe_inst_issuer.sv
// Instruction source for vpipe benches: FIFO-buffered issue with RAW interlock,
// an in-flight tracker up to the retire point, and a saturating cycle counter.
module vpipe_inst_issuer #(
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 3,
  parameter int INTERLOCK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  vpipe_inst_issuer_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef struct packed {
    logic       v;
    logic [1:0] op;
    logic [1:0] rd;
  } trk_t;

  logic [DEPTH-1:0][7:0]   mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  trk_t [LATENCY-1:0]      trk;
  logic [7:0]              head;
  logic [7:0]              inst_q;
  logic                    issue_q, started;
  logic [3:0]              cnt_q;
  logic [2:0]              infl;
  logic                    push, pop, hazard, ready;

  assign head  = mem[rd_ptr];
  assign ready = (count < DEPTH_C);
  assign push  = bus.push_valid && ready;
  assign pop   = !bus.stall && (count != '0) && !hazard;

  // Only producers younger than LATENCY-1 cycles block the head; the oldest
  // tracker slot has its result available by the time the consumer reads.
  always_comb begin
    hazard = 1'b0;
    if (INTERLOCK != 0 && count != '0 && head[7:6] != 2'b00) begin
      for (int k = 0; k <= LATENCY - 2; k++) begin
        if (trk[k].v && (trk[k].rd == head[5:4] || trk[k].rd == head[3:2]))
          hazard = 1'b1;
      end
    end
  end

  always_comb begin
    infl = '0;
    for (int k = 0; k < LATENCY; k++) infl = infl + 3'(trk[k].v);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.push_inst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= 8'h00;
      issue_q <= 1'b0;
      trk     <= '0;
      started <= 1'b0;
      cnt_q   <= 4'h0;
    end else begin
      if (!bus.stall) begin
        inst_q  <= pop ? head : 8'h00;
        issue_q <= pop;
        trk[0]  <= pop ? trk_t'{head[7:6] != 2'b00, head[7:6], head[1:0]} : trk_t'('0);
        for (int i = 1; i < LATENCY; i++) trk[i] <= trk[i-1];
      end else begin
        issue_q <= 1'b0;
      end
      if (pop) started <= 1'b1;
      if (started && cnt_q != 4'hF) cnt_q <= cnt_q + 4'h1;
    end
  end

  assign bus.push_ready   = ready;
  assign bus.inst         = inst_q;
  assign bus.issue        = issue_q;
  assign bus.retire_valid = trk[LATENCY-1].v;
  assign bus.retire_rd    = trk[LATENCY-1].v ? trk[LATENCY-1].rd : 2'b00;
  assign bus.retire_op    = trk[LATENCY-1].v ? trk[LATENCY-1].op : 2'b00;
  assign bus.inflight     = infl;
  assign bus.busy         = (count != '0) || (infl != '0);
  assign bus.cycle_cnt    = cnt_q;
endmodule

// File: tb/tb_vpipe_inst_issuer.sv
// Randomized and directed bench for vpipe_inst_issuer against a queue-based
// model of FIFO order, per-instruction age and the RAW interlock rule.
module tb_vpipe_inst_issuer;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam logic [22:0] RST_VEC = 23'h400000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpipe_inst_issuer_if b();
  vpipe_inst_issuer_if bn();

  vpipe_inst_issuer #(.DEPTH(DEPTH), .LATENCY(LAT), .INTERLOCK(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b));
  vpipe_inst_issuer #(.DEPTH(DEPTH), .LATENCY(LAT), .INTERLOCK(0)) dut_ni (
    .clk(clk), .rst_n(rst_n), .bus(bn));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: FIFO contents plus each in-flight writer with its age.
  typedef struct {
    logic [1:0] op;
    logic [1:0] rd;
    int         age;
  } fl_t;
  logic [7:0] fq[$];
  fl_t        inq[$];
  logic [7:0] m_inst;
  logic       m_issue, m_started;
  int         m_cnt;

  task automatic model_reset();
    fq.delete(); inq.delete();
    m_inst = 8'h00; m_issue = 1'b0; m_started = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic pv, input logic [7:0] pi, input logic st);
    bit rdy, iss, haz;
    logic [7:0] h;
    rdy = (fq.size() < DEPTH);
    iss = 0; haz = 0; h = 8'h00;
    if (!st) begin
      if (fq.size() != 0) begin
        h = fq[0];
        if (h[7:6] != 2'b00)
          foreach (inq[i])
            if (inq[i].age <= LAT - 2 && (inq[i].rd == h[5:4] || inq[i].rd == h[3:2])) haz = 1;
        iss = !haz;
      end
      foreach (inq[i]) inq[i].age = inq[i].age + 1;
      while (inq.size() != 0 && inq[0].age > LAT - 1) void'(inq.pop_front());
      if (iss) begin
        m_inst = h;
        void'(fq.pop_front());
        if (h[7:6] != 2'b00) inq.push_back('{op: h[7:6], rd: h[1:0], age: 0});
      end else m_inst = 8'h00;
    end
    m_issue = iss;
    if (m_started && m_cnt < 15) m_cnt = m_cnt + 1;
    if (iss) m_started = 1'b1;
    if (pv && rdy) fq.push_back(pi);
  endtask

  function automatic logic [22:0] dut_vec();
    return {b.push_ready, b.inst, b.issue, b.retire_valid, b.retire_rd, b.retire_op,
            b.inflight, b.busy, b.cycle_cnt};
  endfunction

  function automatic logic [22:0] exp_vec();
    logic rv; logic [1:0] rrd, rop; logic rdy, bsy;
    rv = 1'b0; rrd = 2'b00; rop = 2'b00;
    if (inq.size() != 0 && inq[0].age == LAT - 1) begin
      rv = 1'b1; rrd = inq[0].rd; rop = inq[0].op;
    end
    rdy = (fq.size() < DEPTH);
    bsy = (fq.size() != 0) || (inq.size() != 0);
    return {rdy, m_inst, m_issue, rv, rrd, rop, 3'(inq.size()), bsy, 4'(m_cnt)};
  endfunction

  task automatic tick(input logic pv, input logic [7:0] pi, input logic st);
    b.push_valid = pv;  b.push_inst = pi;  b.stall = st;
    bn.push_valid = pv; bn.push_inst = pi; bn.stall = st;
    @(posedge clk);
    model_step(pv, pi, st);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    b.push_valid = 0;  b.push_inst = 0;  b.stall = 0;
    bn.push_valid = 0; bn.push_inst = 0; bn.stall = 0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (!b.busy && !bn.busy) begin ok = 1; return; end
      tick(0, 8'h00, 0);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_total++;
    if (dut_vec() !== RST_VEC) $display("FAIL reset got=%h exp=%h", dut_vec(), RST_VEC);
    else n_pass++;
    n_total++;
    if ({bn.push_ready, bn.inst, bn.issue, bn.busy, bn.inflight, bn.cycle_cnt} !== {1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0})
      $display("FAIL reset_ni got busy=%b inst=%h", bn.busy, bn.inst);
    else n_pass++;
  endtask

  task automatic test_single();
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL single n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      if (n == 2) begin
        n_total++;
        if ({b.inst, b.issue} !== {8'h5B, 1'b1}) $display("FAIL single_issue got inst=%h issue=%b exp 5b/1", b.inst, b.issue);
        else n_pass++;
      end
      if (n == 4) begin
        n_total++;
        if ({b.retire_valid, b.retire_rd, b.retire_op} !== {1'b1, 2'd3, 2'b01})
          $display("FAIL single_retire got v=%b rd=%0d op=%0d exp 1/3/1", b.retire_valid, b.retire_rd, b.retire_op);
        else n_pass++;
      end
      if (n >= 2 && n <= 5) begin
        n_total++;
        if (b.inflight !== ((n == 5) ? 3'd0 : 3'd1)) $display("FAIL single_inflight n=%0d got=%0d", n, b.inflight);
        else n_pass++;
      end
      tick(n == 0, 8'h5B, 0);
    end
  endtask

  task automatic test_fill_stall();
    logic [7:0] pushed[5];
    logic [7:0] issued[$];
    int acc;
    bit ok, take;
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL fill_drain got busy=%b exp 0", b.busy); else n_pass++;
    acc = 0;
    for (int i = 0; i < 5; i++) pushed[i] = 8'($urandom);
    for (int n = 0; n < 6; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL fill n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      take = (acc < 5) && b.push_ready;
      tick(acc < 5, pushed[(acc < 5) ? acc : 0], 1);
      if (take) acc++;
    end
    n_total++;
    if (acc !== 4 || b.push_ready !== 1'b0) $display("FAIL fill_full got accepts=%0d ready=%b exp 4/0", acc, b.push_ready);
    else n_pass++;
    for (int n = 0; n < 30; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL drain_order n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      if (b.issue) issued.push_back(b.inst);
      take = (acc < 5) && b.push_ready;
      tick(acc < 5, pushed[(acc < 5) ? acc : 0], 0);
      if (take) acc++;
    end
    n_total++;
    if (issued.size() != 5) $display("FAIL order_count got=%0d exp=5", issued.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_total++;
        if (issued[i] !== pushed[i]) $display("FAIL order i=%0d got=%h exp=%h", i, issued[i], pushed[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_interlock();
    logic [7:0] mi[10], ni[10];
    logic       ms[10], ns[10];
    bit ok;
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL il_drain got busy=%b/%b exp 0", b.busy, bn.busy); else n_pass++;
    for (int n = 0; n < 10; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL interlock n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      mi[n] = b.inst; ms[n] = b.issue; ni[n] = bn.inst; ns[n] = bn.issue;
      tick(n < 2, (n == 0) ? 8'h47 : 8'h8C, 0);
    end
    n_total++;
    if ({mi[2], mi[3], mi[4], mi[5], ms[2], ms[3], ms[4], ms[5]} !== {32'h4700008C, 4'b1001})
      $display("FAIL il_bubble got=%h%h%h%h issue=%b%b%b%b exp 4700008c/1001", mi[2], mi[3], mi[4], mi[5], ms[2], ms[3], ms[4], ms[5]);
    else n_pass++;
    n_total++;
    if ({ni[2], ni[3], ns[2], ns[3]} !== {16'h478C, 2'b11})
      $display("FAIL il_off got=%h%h issue=%b%b exp 478c/11", ni[2], ni[3], ns[2], ns[3]);
    else n_pass++;
  endtask

  task automatic test_nop_no_bubble();
    logic [7:0] mi[10];
    logic       ms[10], rv[10];
    int nret;
    bit ok;
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL nop_drain got busy=%b exp 0", b.busy); else n_pass++;
    nret = 0;
    for (int n = 0; n < 10; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL nop n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      mi[n] = b.inst; ms[n] = b.issue; rv[n] = b.retire_valid;
      if (b.retire_valid) nret++;
      tick(n < 2, (n == 0) ? 8'h03 : 8'h4C, 0);
    end
    n_total++;
    if ({mi[2], mi[3], ms[2], ms[3]} !== {16'h034C, 2'b11})
      $display("FAIL nop_issue got=%h%h issue=%b%b exp 034c/11", mi[2], mi[3], ms[2], ms[3]);
    else n_pass++;
    n_total++;
    if (nret !== 1 || rv[4] !== 1'b0 || rv[5] !== 1'b1)
      $display("FAIL nop_retire got count=%0d rv4=%b rv5=%b exp 1/0/1", nret, rv[4], rv[5]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit ok;
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL ar_drain got busy=%b exp 0", b.busy); else n_pass++;
    tick(1, 8'h41, 0);
    tick(1, 8'h42, 0);
    tick(0, 8'h00, 0);
    tick(1, 8'h43, 1);
    tick(1, 8'h41, 1);
    tick(1, 8'h42, 1);
    n_total++;
    if (dut_vec() !== exp_vec() || b.inflight !== 3'd2 || b.push_ready !== 1'b1)
      $display("FAIL ar_setup got=%h exp=%h inflight=%0d", dut_vec(), exp_vec(), b.inflight);
    else n_pass++;
    #2;
    b.push_valid = 0; b.stall = 0; bn.push_valid = 0; bn.stall = 0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_vec() !== RST_VEC) $display("FAIL ar_midcycle got=%h exp=%h", dut_vec(), RST_VEC);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      n_total++;
      if (b.busy !== 1'b0 || b.inst !== 8'h00 || dut_vec() !== exp_vec())
        $display("FAIL ar_after n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      tick(0, 8'h00, 0);
    end
  endtask

  task automatic test_cycle_cnt();
    int e;
    reset_dut();
    for (int n = 0; n < 23; n++) begin
      e = (n < 2) ? 0 : ((n - 2 > 15) ? 15 : n - 2);
      n_total++;
      if (b.cycle_cnt !== 4'(e) || dut_vec() !== exp_vec())
        $display("FAIL cycle_cnt n=%0d got=%0d exp=%0d", n, b.cycle_cnt, e);
      else n_pass++;
      tick(n == 0, 8'h41, 0);
    end
  endtask

  task automatic test_random();
    logic pv, st;
    logic [7:0] pi;
    for (int n = 0; n < 300; n++) begin
      n_total++;
      if (dut_vec() !== exp_vec()) $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      else n_pass++;
      pv = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      pi = 8'($urandom);
      tick(pv, pi, st);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b.push_valid = 0;  b.push_inst = 0;  b.stall = 0;
    bn.push_valid = 0; bn.push_inst = 0; bn.stall = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_stall();
    test_interlock();
    test_nop_no_bubble();
    test_async_reset();
    test_cycle_cnt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
